// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous SRAM.
// Requester 0 is read-only; requester 1 reads or writes with byte strobes.
module mem_port_arbiter #(
  parameter int READ_LAT = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req0_valid,
  input  logic [13:0] req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [13:0] req1_addr,
  input  logic [3:0]  req1_wstrb,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        CS,
  output logic        OE,
  output logic [3:0]  WEB,
  output logic [13:0] A,
  output logic [31:0] DI,
  input  logic [31:0] DO
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic [3:0]  web_q, web_d;
  logic [13:0] a_q, a_d;
  logic [31:0] di_q, di_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;

  logic grant_id;
  logic accept;
  logic new_we;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_id   = req0_valid ? (req1_valid & ~last_grant_q) : 1'b1;
    req0_ready = (state_q == IDLE) & req0_valid & ~grant_id;
    req1_ready = (state_q == IDLE) & req1_valid & grant_id;
  end

  assign accept = req0_ready | req1_ready;
  assign new_we = grant_id & req1_we;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    cs_d         = 1'b0;
    oe_d         = 1'b0;
    web_d        = 4'b1111;
    a_d          = a_q;
    di_d         = di_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = CMD;
          last_grant_d = grant_id;
          gnt_d        = grant_id;
          we_d         = new_we;
          // SRAM pins are registered, so the command is set up on the accepting edge.
          cs_d         = 1'b1;
          oe_d         = ~new_we;
          web_d        = new_we ? ~req1_wstrb : 4'b1111;
          a_d          = grant_id ? req1_addr : req0_addr;
          if (new_we) di_d = req1_wdata;
        end
      end
      CMD: begin
        if (we_q) begin
          state_d      = RESP;
          rsp0_valid_d = ~gnt_q;
          rsp1_valid_d = gnt_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          cs_d    = 1'b1;
          oe_d    = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d      = RESP;
          rsp0_valid_d = ~gnt_q;
          rsp1_valid_d = gnt_q;
          if (gnt_q) rsp1_data_d = DO;
          else       rsp0_data_d = DO;
        end else begin
          cnt_d = cnt_q - 2'd1;
          cs_d  = 1'b1;
          oe_d  = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= 2'd0;
      cs_q         <= 1'b0;
      oe_q         <= 1'b0;
      web_q        <= 4'b1111;
      a_q          <= '0;
      di_q         <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      cs_q         <= cs_d;
      oe_q         <= oe_d;
      web_q        <= web_d;
      a_q          <= a_d;
      di_q         <= di_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign CS         = cs_q;
  assign OE         = oe_q;
  assign WEB        = web_q;
  assign A          = a_q;
  assign DI         = di_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: SRAM model, reference memory and
// a response scoreboard filled at acceptance and drained at rsp_valid.
module tb_mem_port_arbiter;

  localparam int RL = 2;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req0_valid, req0_ready;
  logic [13:0] req0_addr;
  logic        req1_valid, req1_we, req1_ready;
  logic [13:0] req1_addr;
  logic [3:0]  req1_wstrb;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        CS, OE;
  logic [3:0]  WEB;
  logic [13:0] A;
  logic [31:0] DI, DO;

  always #5 ACLK = ~ACLK;

  mem_port_arbiter #(.READ_LAT(RL)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wstrb(req1_wstrb), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  typedef struct {
    logic        id;
    logic        we;
    logic [13:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] data;
    int          acc;
  } txn_t;

  txn_t sb[$];
  int   grant_log[$];
  int   acc_cyc_log[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_count = 0;
  int both_ready_viol = 0;
  int unexpected_rsp = 0;
  int cs_cnt = 0;
  int rd_age = 0;
  logic [31:0] exp_rsp0 = '0;
  logic [31:0] exp_rsp1 = '0;

  logic [31:0] ref_mem [0:16383];
  logic [31:0] sram    [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // SRAM model: DO is only meaningful READ_LAT cycles into a read command.
  always @(posedge ACLK) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (CS) begin
      for (int b = 0; b < 4; b++)
        if (!WEB[b]) sram[A][b*8 +: 8] <= DI[b*8 +: 8];
    end
    rd_age <= (CS && OE) ? rd_age + 1 : 0;
  end
  assign DO = (CS && OE && rd_age == RL) ? sram[A] : 32'h0BAD_F00D;

  // Monitor: responses, command cycle pins, acceptances.
  always @(negedge ACLK) begin
    txn_t        t;
    logic [3:0]  web_exp;
    if (ARESET) begin
      sb.delete();
      exp_rsp0 = '0;
      exp_rsp1 = '0;
      cs_cnt   = 0;
    end else begin
      if (req0_ready && req1_ready) both_ready_viol++;
      if (CS) cs_cnt++;
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) unexpected_rsp++;
        else begin
          t = sb.pop_front();
          check("rsp_id", {30'b0, rsp1_valid, rsp0_valid}, t.id ? 32'd2 : 32'd1);
          check("rsp_latency", cyc - t.acc, t.we ? 2 : RL + 2);
          check("cs_cycles", cs_cnt, t.we ? 1 : RL + 1);
          if (!t.id) begin
            check("rsp0_data", rsp0_data, t.data);
            check("rsp1_hold", rsp1_data, exp_rsp1);
            exp_rsp0 = t.data;
          end else begin
            check("rsp1_data", rsp1_data, t.we ? exp_rsp1 : t.data);
            check("rsp0_hold", rsp0_data, exp_rsp0);
            if (!t.we) exp_rsp1 = t.data;
          end
        end
      end
      if (sb.size() > 0 && cyc == sb[0].acc + 1) begin
        web_exp = sb[0].we ? ~sb[0].wstrb : 4'b1111;
        check("cmd_cs", CS, 1);
        check("cmd_a", A, sb[0].addr);
        check("cmd_oe", OE, !sb[0].we);
        check("cmd_web", WEB, web_exp);
        if (sb[0].we) check("cmd_di", DI, sb[0].wdata);
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        t.id    = req1_valid && req1_ready;
        t.we    = t.id ? req1_we : 1'b0;
        t.addr  = t.id ? req1_addr : req0_addr;
        t.wstrb = req1_wstrb;
        t.wdata = req1_wdata;
        t.data  = ref_mem[t.addr];
        t.acc   = cyc;
        sb.push_back(t);
        grant_log.push_back(int'(t.id));
        acc_cyc_log.push_back(cyc);
        acc_count++;
        cs_cnt = 0;
      end
    end
  end

  task automatic preload(input logic [13:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
    @(posedge ACLK); #1;
    pl_en = 1'b0;
    ref_mem[addr] = data;
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int i = 0; i < 64 && acc_count < target; i++) @(posedge ACLK);
    check({tag, "_accepted"}, acc_count >= target, 1);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge ACLK);
    check({tag, "_drained"}, sb.size(), 0);
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic issue0(input logic [13:0] addr);
    req0_addr = addr; req0_valid = 1'b1;
    wait_acc(acc_count + 1, "acc0");
    req0_valid = 1'b0;
  endtask

  task automatic issue1(input logic we, input logic [13:0] addr,
                        input logic [3:0] wstrb, input logic [31:0] wdata);
    req1_we = we; req1_addr = addr; req1_wstrb = wstrb; req1_wdata = wdata;
    req1_valid = 1'b1;
    wait_acc(acc_count + 1, "acc1");
    req1_valid = 1'b0;
    if (we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {26'b0, CS, OE, WEB}, 32'h0000_000F);
    check({tag, "_a"}, A, 0);
    check({tag, "_di"}, DI, 0);
    check({tag, "_rsp_valid"}, {30'b0, rsp1_valid, rsp0_valid}, 0);
    check({tag, "_rsp0_data"}, rsp0_data, 0);
    check({tag, "_rsp1_data"}, rsp1_data, 0);
  endtask

  task automatic pulse_reset(input string tag);
    ARESET = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  initial begin
    int base;
    int gbase;
    ARESET = 1'b1;
    req0_valid = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wstrb = '0; req1_wdata = '0;

    preload(14'h0010, 32'hDEAD_BEEF);
    preload(14'h0011, 32'h0123_4567);
    preload(14'h0012, 32'h89AB_CDEF);
    preload(14'h0020, 32'hAABB_CCDD);
    preload(14'h0030, 32'h3030_3030);
    preload(14'h0040, 32'h4040_4040);
    preload(14'h0050, 32'h5555_5555);
    check_reset_outputs("reset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK); #1;

    // Single read from requester 0.
    issue0(14'h0010);
    drain("read0");

    // Partial-strobe write, read-back, zero-strobe write, read-back.
    issue1(1'b1, 14'h0020, 4'b0101, 32'h1122_3344);
    drain("write_partial");
    issue1(1'b0, 14'h0020, 4'b0000, 32'h0);
    drain("readback1");
    issue1(1'b1, 14'h0020, 4'b0000, 32'hFFFF_FFFF);
    drain("write_nostrb");
    issue0(14'h0020);
    drain("readback0");

    // Both requesters valid continuously after reset: expect 0,1,0,1.
    pulse_reset("rst_rr");
    base  = acc_count;
    gbase = grant_log.size();
    req0_addr = 14'h0030; req0_valid = 1'b1;
    req1_we = 1'b0; req1_addr = 14'h0040; req1_valid = 1'b1;
    wait_acc(base + 4, "rr");
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("rr");
    for (int k = 0; k < 4; k++) check("rr_grant", grant_log[gbase + k], k % 2);

    // Back-to-back reads from requester 0 alone.
    base  = acc_count;
    gbase = grant_log.size();
    req0_addr = 14'h0010; req0_valid = 1'b1;
    wait_acc(base + 1, "b2b");
    req0_addr = 14'h0011;
    wait_acc(base + 2, "b2b");
    req0_addr = 14'h0012;
    wait_acc(base + 3, "b2b");
    req0_valid = 1'b0;
    drain("b2b");
    for (int k = 0; k < 2; k++)
      check("b2b_spacing", acc_cyc_log[gbase + k + 1] - acc_cyc_log[gbase + k], RL + 3);
    for (int k = 0; k < 3; k++) check("b2b_grant", grant_log[gbase + k], 0);

    // Reset during WAIT aborts the read; a following write completes.
    issue0(14'h0010);
    @(posedge ACLK); #1;
    pulse_reset("rst_wait");
    repeat (8) @(posedge ACLK); #1;
    check("abort_no_rsp", unexpected_rsp, 0);
    issue1(1'b1, 14'h0050, 4'b1111, 32'hCAFE_F00D);
    drain("post_rst_write");
    issue0(14'h0050);
    drain("post_rst_read");

    check("both_ready", both_ready_viol, 0);
    check("unexpected_rsp", unexpected_rsp, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
